// File: rtl/tl_channel_monitor.sv
// tl_channel_monitor: passive protocol checker for one TileLink-UH A/D channel pair.
// Tracks outstanding requests per source, counts burst beats, checks that stalled
// channels hold their fields, and matches response opcode/size to the request.
// Violations are reported through registered outputs one edge after sampling.
// Optional build macro TL_MONITOR_STOP_EN: report each registered error and
// stop the simulation with $fatal (not compiled under SYNTHESIS).
module tl_channel_monitor #(
  parameter int unsigned SOURCE_BITS   = 4,
  parameter int unsigned SIZE_BITS     = 3,
  parameter int unsigned BEAT_LOG2     = 2,
  parameter int unsigned MAX_SIZE_LOG2 = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_param,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [2:0]             d_param,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic [9:0]             err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int unsigned NSRC = 1 << SOURCE_BITS;
  localparam int unsigned CW   = MAX_SIZE_LOG2 - BEAT_LOG2 + 1;
  localparam int unsigned HW   = 6 + SIZE_BITS + SOURCE_BITS;
  localparam int unsigned BW   = 3 + SIZE_BITS + SOURCE_BITS;

  // Index of the last beat of a burst; out-of-range sizes count as one beat.
  function automatic logic [CW-1:0] last_idx(input logic has_data,
                                             input logic [SIZE_BITS-1:0] size);
    int unsigned s;
    s = 32'(size);
    if (!has_data || s <= BEAT_LOG2 || s > MAX_SIZE_LOG2) return '0;
    return CW'((32'd1 << (s - BEAT_LOG2)) - 32'd1);
  endfunction

  // Response opcode that a legal request opcode must be answered with.
  function automatic logic [2:0] exp_d_op(input logic [2:0] op);
    case (op)
      3'd0, 3'd1:       return 3'd0;
      3'd2, 3'd3, 3'd4: return 3'd1;
      3'd5:             return 3'd2;
      default:          return 3'd0;
    endcase
  endfunction

  // Per-source table
  logic [NSRC-1:0]      busy_q;
  logic [2:0]           exp_op_q [NSRC];
  logic [SIZE_BITS-1:0] size_q   [NSRC];

  // Burst state
  logic [CW-1:0] a_cnt_q, a_last_q, d_cnt_q, d_last_q;
  logic [BW-1:0] a_burst_q, d_burst_q;

  // Stall trackers
  logic          a_stall_q, d_stall_q;
  logic [HW-1:0] a_hold_q, d_hold_q;

  // Combinational decode
  logic a_fire, d_fire, a_first, d_first, a_last, d_last;
  logic a_legal, a_alloc, d_busy, d_retire, a_busy_eff;
  logic [CW-1:0] a_last_new, d_last_new;
  logic [HW-1:0] a_fields, d_fields;
  logic [BW-1:0] a_bfields, d_bfields;
  logic [9:0] err_vec;
  logic [3:0] code_d;
  logic [NSRC-1:0] busy_d;
  logic [SOURCE_BITS:0] cnt_d;

  // Classify this cycle's handshakes and collect every violation.
  always_comb begin
    a_fire     = a_valid & a_ready;
    d_fire     = d_valid & d_ready;
    a_fields   = {a_opcode, a_param, a_size, a_source};
    d_fields   = {d_opcode, d_param, d_size, d_source};
    a_bfields  = {a_opcode, a_size, a_source};
    d_bfields  = {d_opcode, d_size, d_source};
    a_first    = (a_cnt_q == '0);
    d_first    = (d_cnt_q == '0);
    a_legal    = !(a_opcode[2] & a_opcode[1]) && (32'(a_size) <= MAX_SIZE_LOG2);
    a_last_new = last_idx(a_legal & ~a_opcode[2], a_size);
    d_last_new = last_idx(d_opcode == 3'd1, d_size);
    a_last     = a_first ? (a_last_new == '0) : (a_cnt_q == a_last_q);
    d_last     = d_first ? (d_last_new == '0) : (d_cnt_q == d_last_q);
    d_busy     = busy_q[d_source];
    d_retire   = d_fire & d_last & d_busy;
    // A retire landing on the same source frees it before the new request is judged.
    a_busy_eff = busy_q[a_source] & ~(d_retire && (d_source == a_source));
    a_alloc    = a_fire & a_first & a_legal;

    err_vec    = '0;
    err_vec[0] = a_valid & a_opcode[2] & a_opcode[1];
    err_vec[1] = a_valid & (32'(a_size) > MAX_SIZE_LOG2);
    err_vec[2] = a_stall_q & (!a_valid || (a_fields != a_hold_q));
    err_vec[3] = a_alloc & a_busy_eff;
    err_vec[4] = a_fire & !a_first & (a_bfields != a_burst_q);
    err_vec[5] = d_fire & !d_busy;
    err_vec[6] = d_fire & d_busy & (d_opcode != exp_op_q[d_source]);
    err_vec[7] = d_fire & d_busy & (d_size != size_q[d_source]);
    err_vec[8] = d_stall_q & (!d_valid || (d_fields != d_hold_q));
    err_vec[9] = d_fire & !d_first & (d_bfields != d_burst_q);

    code_d = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (err_vec[i] && code_d == '0) code_d = 4'(i + 1);
    end

    busy_d = busy_q;
    if (d_retire) busy_d[d_source] = 1'b0;
    if (a_alloc)  busy_d[a_source] = 1'b1;

    cnt_d = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      cnt_d = cnt_d + (SOURCE_BITS + 1)'(busy_d[i]);
    end
  end

  // Table, burst counters, stall trackers and registered error outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
        exp_op_q[i] <= '0;
        size_q[i]   <= '0;
      end
      a_cnt_q      <= '0;
      a_last_q     <= '0;
      a_burst_q    <= '0;
      d_cnt_q      <= '0;
      d_last_q     <= '0;
      d_burst_q    <= '0;
      a_stall_q    <= 1'b0;
      d_stall_q    <= 1'b0;
      a_hold_q     <= '0;
      d_hold_q     <= '0;
      err_valid    <= 1'b0;
      err_code     <= '0;
      err_sticky   <= '0;
      inflight_cnt <= '0;
    end else begin
      busy_q <= busy_d;
      if (a_alloc) begin
        exp_op_q[a_source] <= exp_d_op(a_opcode);
        size_q[a_source]   <= a_size;
      end

      if (a_fire) begin
        if (a_first) begin
          a_burst_q <= a_bfields;
          a_last_q  <= a_last_new;
        end
        a_cnt_q <= a_last ? '0 : a_cnt_q + CW'(1);
      end

      if (d_fire) begin
        if (d_first) begin
          d_burst_q <= d_bfields;
          d_last_q  <= d_last_new;
        end
        d_cnt_q <= d_last ? '0 : d_cnt_q + CW'(1);
      end

      a_stall_q <= a_valid & ~a_ready;
      d_stall_q <= d_valid & ~d_ready;
      a_hold_q  <= a_fields;
      d_hold_q  <= d_fields;

      err_valid    <= |err_vec;
      err_code     <= code_d;
      err_sticky   <= err_sticky | err_vec;
      inflight_cnt <= cnt_d;
    end
  end

`ifdef TL_MONITOR_STOP_EN
`ifndef SYNTHESIS
  // Halt the simulation at the edge that registers a violation.
  always_ff @(posedge clock) begin
    if (reset_n && code_d != '0) begin
      $display("tl_channel_monitor: error code %0d source %0d",
               code_d, (code_d <= 4'd5) ? a_source : d_source);
      $fatal(1, "tl_channel_monitor: protocol violation");
    end
  end
`endif
`else
  // Flag-only build: violations are visible solely on the error outputs.
`endif

endmodule

// File: tb/tb_tl_channel_monitor.sv
// Directed-vector bench for tl_channel_monitor with a queue-based scoreboard.
module tb_tl_channel_monitor;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, a_ready = 1'b1;
  logic [2:0] a_opcode = '0, a_param = '0, a_size = '0;
  logic [3:0] a_source = '0;
  logic       d_valid = 1'b0, d_ready = 1'b1;
  logic [2:0] d_opcode = '0, d_param = '0, d_size = '0;
  logic [3:0] d_source = '0;
  logic       err_valid;
  logic [3:0] err_code;
  logic [9:0] err_sticky;
  logic [4:0] inflight_cnt;

  tl_channel_monitor #(
    .SOURCE_BITS(4), .SIZE_BITS(3), .BEAT_LOG2(2), .MAX_SIZE_LOG2(6)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .inflight_cnt(inflight_cnt)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int unsigned due;
    logic [3:0]  code;
    logic [9:0]  sticky;
    logic [4:0]  infl;
  } exp_t;

  exp_t        sb[$];
  logic [9:0]  sticky_m = '0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs against every expectation due by this cycle.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("err_valid",    32'(err_valid),    32'(e.code != 4'd0));
      chk("err_code",     32'(err_code),     32'(e.code));
      chk("err_sticky",   32'(err_sticky),   32'(e.sticky));
      chk("inflight_cnt", 32'(inflight_cnt), 32'(e.infl));
    end
  end

  // Drive one cycle of stimulus and queue the expected outputs after its edge.
  task automatic step(input logic av, input logic ar, input logic [2:0] aop,
                      input logic [2:0] asz, input logic [3:0] asrc,
                      input logic dv, input logic dr, input logic [2:0] dop,
                      input logic [2:0] dsz, input logic [3:0] dsrc,
                      input logic [3:0] code, input logic [4:0] infl);
    exp_t e;
    a_valid = av; a_ready = ar; a_opcode = aop; a_size = asz; a_source = asrc;
    d_valid = dv; d_ready = dr; d_opcode = dop; d_size = dsz; d_source = dsrc;
    if (code != 4'd0) sticky_m = sticky_m | (10'd1 << (code - 4'd1));
    e.due = cyc + 1; e.code = code; e.sticky = sticky_m; e.infl = infl;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic a_tx(input logic ar, input logic [2:0] op, input logic [2:0] sz,
                      input logic [3:0] src, input logic [3:0] code, input logic [4:0] infl);
    step(1'b1, ar, op, sz, src, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, code, infl);
  endtask

  task automatic d_tx(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                      input logic [3:0] code, input logic [4:0] infl);
    step(1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, op, sz, src, code, infl);
  endtask

  task automatic idle(input logic [4:0] infl);
    step(1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 4'd0, infl);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " err_valid"},    32'(err_valid),    0);
    chk({tag, " err_code"},     32'(err_code),     0);
    chk({tag, " err_sticky"},   32'(err_sticky),   0);
    chk({tag, " inflight_cnt"}, 32'(inflight_cnt), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_zero("in_reset");
    reset_n = 1'b1;
    idle(5'd0);

    // Get size 2 source 3, AccessAckData one cycle later
    a_tx(1'b1, 3'd4, 3'd2, 4'd3, 4'd0, 5'd1);
    d_tx(3'd1, 3'd2, 4'd3, 4'd0, 5'd0);

    // PutFull size 4 (4 beats), size changes on beat 2
    a_tx(1'b1, 3'd0, 3'd4, 4'd1, 4'd0, 5'd1);
    a_tx(1'b1, 3'd0, 3'd4, 4'd1, 4'd0, 5'd1);
    a_tx(1'b1, 3'd0, 3'd3, 4'd1, 4'd5, 5'd1);
    a_tx(1'b1, 3'd0, 3'd4, 4'd1, 4'd0, 5'd1);
    d_tx(3'd0, 3'd4, 4'd1, 4'd0, 5'd0);

    // A stalled, source changes 5 -> 6; single-cycle pulse
    a_tx(1'b0, 3'd4, 3'd2, 4'd5, 4'd0, 5'd0);
    a_tx(1'b0, 3'd4, 3'd2, 4'd6, 4'd3, 5'd0);
    a_tx(1'b1, 3'd4, 3'd2, 4'd6, 4'd0, 5'd1);
    idle(5'd1);
    d_tx(3'd1, 3'd2, 4'd6, 4'd0, 5'd0);

    // Busy source, idle-source response, wrong response opcode
    a_tx(1'b1, 3'd4, 3'd2, 4'd7, 4'd0, 5'd1);
    a_tx(1'b1, 3'd4, 3'd2, 4'd7, 4'd4, 5'd1);
    d_tx(3'd1, 3'd2, 4'd9, 4'd6, 5'd1);
    d_tx(3'd0, 3'd2, 4'd7, 4'd7, 5'd0);

    // Same-cycle retire and allocate on source 2
    a_tx(1'b1, 3'd4, 3'd2, 4'd2, 4'd0, 5'd1);
    step(1'b1, 1'b1, 3'd4, 3'd2, 4'd2, 1'b1, 1'b1, 3'd1, 3'd2, 4'd2, 4'd0, 5'd1);
    d_tx(3'd1, 3'd2, 4'd2, 4'd0, 5'd0);

    // Illegal opcode, oversize, response size mismatch
    a_tx(1'b1, 3'd6, 3'd2, 4'd10, 4'd1, 5'd0);
    a_tx(1'b1, 3'd4, 3'd7, 4'd11, 4'd2, 5'd0);
    a_tx(1'b1, 3'd4, 3'd2, 4'd3, 4'd0, 5'd1);
    d_tx(3'd1, 3'd1, 4'd3, 4'd8, 5'd0);

    // D stall with source change, then fire on an idle source
    step(1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd1, 3'd2, 4'd4, 4'd0, 5'd0);
    step(1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 3'd1, 3'd2, 4'd5, 4'd9, 5'd0);
    step(1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 1'b1, 1'b1, 3'd1, 3'd2, 4'd5, 4'd6, 5'd0);
    idle(5'd0);

    // Three sources busy, PutFull mid-burst and stalled
    a_tx(1'b1, 3'd4, 3'd2, 4'd0, 4'd0, 5'd1);
    a_tx(1'b1, 3'd4, 3'd2, 4'd4, 4'd0, 5'd2);
    a_tx(1'b1, 3'd0, 3'd4, 4'd8, 4'd0, 5'd3);
    a_tx(1'b1, 3'd0, 3'd4, 4'd8, 4'd0, 5'd3);
    a_tx(1'b0, 3'd0, 3'd4, 4'd8, 4'd0, 5'd3);

    // Asynchronous reset mid-burst
    @(negedge clock);
    #2;
    chk("queue_drained_before_reset", 32'(sb.size()), 0);
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    sticky_m = '0;
    a_valid = 1'b1; a_ready = 1'b0; a_source = 4'd13;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Fresh traffic after release: no stall carry-over, counters restarted
    a_tx(1'b1, 3'd4, 3'd2, 4'd9, 4'd0, 5'd1);
    d_tx(3'd1, 3'd2, 4'd9, 4'd0, 5'd0);
    a_tx(1'b1, 3'd1, 3'd3, 4'd5, 4'd0, 5'd1);
    a_tx(1'b1, 3'd1, 3'd3, 4'd5, 4'd0, 5'd1);
    d_tx(3'd0, 3'd3, 4'd5, 4'd0, 5'd0);
    a_tx(1'b1, 3'd4, 3'd3, 4'd12, 4'd0, 5'd1);
    d_tx(3'd1, 3'd3, 4'd12, 4'd0, 5'd1);
    d_tx(3'd1, 3'd3, 4'd12, 4'd0, 5'd0);
    idle(5'd0);

    repeat (2) @(negedge clock);
    chk("queue_drained_at_end", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
